trail_frame_sched: RTL and testbench
====================================

Name: trail_frame_sched

Overview:
- Sequences the trail_iir blend datapath for each camera pixel.
- For each accepted camera pixel it:
  - reads the stored history pixel from the history frame buffer;
  - presents camera and history pixels together to trail_iir;
  - writes trail_iir's update back to the same address.
- Also owns the history buffer's write port for power-up clear and user clear.
- Sits between the camera pixel stream, the history BRAM and trail_iir.

Parameters:
- ADDR_W, 17, history buffer address width.
- NUM_PIXELS, 76800, pixels per frame (clear sweep length); must exceed MAX_INFLIGHT+RD_LAT.
- RD_LAT, 2, history BRAM read latency in cycles (≥1).
- MAX_INFLIGHT, 8, maximum pixels accepted but not yet written back; also tag FIFO depth.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous active-high reset.
- clear_in  input  1  single-cycle request to zero the history buffer.
- cam_valid_in  input  1  camera pixel valid.
- cam_ready_out  output  1  scheduler can accept a camera pixel.
- cam_pixel_in  input  24  camera RGB888.
- cam_addr_in  input  ADDR_W  frame-buffer address of the camera pixel.
- hist_rd_en_out  output  1  history read strobe.
- hist_rd_addr_out  output  ADDR_W  history read address.
- hist_rd_data_in  input  24  history data, valid RD_LAT cycles after the strobe.
- iir_valid_out  output  1  to trail_iir valid_in.
- iir_history_out  output  24  to trail_iir history_in.
- iir_camera_out  output  24  to trail_iir camera_in.
- iir_valid_in  input  1  from trail_iir valid_out.
- iir_update_in  input  24  from trail_iir update_out.
- hist_wr_en_out  output  1  history write strobe.
- hist_wr_addr_out  output  ADDR_W  history write address.
- hist_wr_data_out  output  24  history write data.
- clearing_out  output  1  clear sweep in progress.
- err_out  output  1  sticky protocol error.

Behaviour:
- Reset (async):
  - All outputs are 0.
  - State=CLEAR, sweep address=0, in-flight count=0, tag FIFO empty, clear_pending=0.
  - Delay-line valids are cleared.
  - Reset mid-operation abandons all in-flight work.
- States:
  - CLEAR:
    - clearing_out=1, cam_ready_out=0.
    - Each cycle: hist_wr_en_out=1, addr=sweep, data=0; sweep increments.
    - After address NUM_PIXELS-1 is written, next state is RUN.
    - clear_in during CLEAR restarts the sweep at 0.
  - RUN:
    - cam_ready_out = (inflight < MAX_INFLIGHT) && !clear_pending.
    - Accept = cam_valid_in && cam_ready_out. On accept, in the same cycle:
      - hist_rd_en_out=1, hist_rd_addr_out=cam_addr_in;
      - cam_pixel_in and a valid bit enter an RD_LAT-deep delay line;
      - cam_addr_in is pushed to the tag FIFO;
      - inflight increments.
    - iir_valid_out asserts exactly RD_LAT cycles after accept, with:
      - iir_history_out=hist_rd_data_in;
      - iir_camera_out=delayed pixel.
    - Dispatch is combinational from the delay-line tail (no extra register).
    - clear_in sets clear_pending; next state is DRAIN.
  - DRAIN:
    - cam_ready_out=0.
    - When inflight==0 (checked after this cycle's writeback), next state is CLEAR with sweep=0; clear_pending clears.
- Writeback (RUN and DRAIN):
  - On iir_valid_in with the tag FIFO non-empty: pop the tag, decrement inflight.
  - Registered write one cycle later: hist_wr_en_out=1, addr=tag, data=iir_update_in.
- Write-port ownership:
  - Writeback and the sweep never overlap: CLEAR is entered only with inflight==0.
  - The last writeback register drains during the first CLEAR cycle; the sweep starts the following cycle, so the port has one driver per cycle.
- Simultaneous accept and writeback: inflight unchanged; FIFO push and pop both happen.
- Errors:
  - iir_valid_in with the tag FIFO empty: err_out=1 (sticky until reset), no write.
  - iir_valid_in while in CLEAR: same handling.
- Ordering:
  - trail_iir is in-order, so writeback addresses appear in accept order.
  - No read-after-write hazard check; the NUM_PIXELS constraint guarantees no address repeats within the in-flight window.
- Counter width: $clog2(MAX_INFLIGHT+1); sweep counter width ADDR_W.

Decomposition:
- Package trail_pkg:
  - pixel_t (logic [23:0]);
  - sched_state_t enum {CLEAR, RUN, DRAIN};
  - default NUM_PIXELS constant.
- One sub-module: trail_tag_fifo.
  - Synchronous FIFO, width ADDR_W, depth MAX_INFLIGHT.
  - Ports: push, pop, full, empty.
  - Async reset to empty.

Test Plan:
- Reset, NUM_PIXELS=16: hist_wr_en_out high 16 consecutive cycles, addr 0..15, data 0. clearing_out then falls and cam_ready_out=1 the next cycle.
- Single pixel, RD_LAT=2: addr 5, pixel 0x123456; memory model returns 0xFAF078.
  - iir_valid_out exactly 2 cycles after accept, with history 0xFAF078 and camera 0x123456.
  - Model returns 0xABCDEF → one cycle later a write to addr 5 with data 0xABCDEF.
- Back-pressure: 10 back-to-back pixels at addr 0..9 with trail_iir model latency 20.
  - Ready drops after 8 accepts.
  - Ready rises the cycle after the first writeback.
  - Writes occur to addr 0..9 in order.
- Clear mid-run with 3 in flight:
  - Ready low from the next cycle.
  - 3 writebacks complete.
  - Then the 16-cycle zero sweep, then ready high.
- At inflight=7: accept and iir_valid_in in the same cycle → inflight stays 7, ready stays high.
- Error and mid-sweep reset:
  - iir_valid_in with nothing in flight → err_out=1, no hist write.
  - rst_in asserted at sweep addr 9 → outputs 0 immediately; sweep restarts at 0 after release.

Source files
------------

// File: rtl/trail_pkg.sv
// Shared types and defaults for the trail blend scheduler.
package trail_pkg;

    typedef logic [23:0] pixel_t;

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        DRAIN
    } sched_state_t;

    localparam int NUM_PIXELS_DEFAULT = 76800;

endpackage

// File: rtl/trail_tag_fifo.sv
// Synchronous FIFO that remembers the frame-buffer address of every pixel still inside trail_iir.
module trail_tag_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/trail_frame_sched.sv
// Per-pixel scheduler: reads history, dispatches camera+history to trail_iir, writes the blend back.
// Also owns the history write port for the power-up and user-requested clear sweep.
module trail_frame_sched
    import trail_pkg::*;
#(
    parameter int ADDR_W       = 17,
    parameter int NUM_PIXELS   = NUM_PIXELS_DEFAULT,
    parameter int RD_LAT       = 2,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              clear_in,
    input  logic              cam_valid_in,
    output logic              cam_ready_out,
    input  logic [23:0]       cam_pixel_in,
    input  logic [ADDR_W-1:0] cam_addr_in,
    output logic              hist_rd_en_out,
    output logic [ADDR_W-1:0] hist_rd_addr_out,
    input  logic [23:0]       hist_rd_data_in,
    output logic              iir_valid_out,
    output logic [23:0]       iir_history_out,
    output logic [23:0]       iir_camera_out,
    input  logic              iir_valid_in,
    input  logic [23:0]       iir_update_in,
    output logic              hist_wr_en_out,
    output logic [ADDR_W-1:0] hist_wr_addr_out,
    output logic [23:0]       hist_wr_data_out,
    output logic              clearing_out,
    output logic              err_out
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0]     MAX_CNT   = CW'(MAX_INFLIGHT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    sched_state_t      state, state_next;
    logic [ADDR_W-1:0] sweep, sweep_next;
    logic [CW-1:0]     inflight, inflight_next;
    logic              clear_pending, clear_pending_next;
    logic [RD_LAT-1:0] dl_valid;
    pixel_t            dl_pixel [RD_LAT];
    logic              accept;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] tag;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    pixel_t            wr_data_q;
    logic              clearing_q;
    logic              err_q;

    // Ready also waits for the last sweep write to leave the port register.
    assign cam_ready_out = (state == RUN) && (inflight < MAX_CNT) && !clear_pending
                           && !clearing_q && !fifo_full;
    assign accept           = cam_valid_in && cam_ready_out;
    assign hist_rd_en_out   = accept;
    assign hist_rd_addr_out = accept ? cam_addr_in : '0;

    assign iir_valid_out   = dl_valid[RD_LAT-1];
    assign iir_history_out = iir_valid_out ? hist_rd_data_in : '0;
    assign iir_camera_out  = iir_valid_out ? dl_pixel[RD_LAT-1] : '0;

    assign pop = iir_valid_in && !fifo_empty && (state != CLEAR);

    assign hist_wr_en_out   = wr_en_q;
    assign hist_wr_addr_out = wr_addr_q;
    assign hist_wr_data_out = wr_data_q;
    assign clearing_out     = clearing_q;
    assign err_out          = err_q;

    trail_tag_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (MAX_INFLIGHT)
    ) u_tag_fifo (
        .clk       (clk_in),
        .rst       (rst_in),
        .push      (accept),
        .push_data (cam_addr_in),
        .pop       (pop),
        .pop_data  (tag),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_next         = state;
        sweep_next         = sweep;
        clear_pending_next = clear_pending;
        inflight_next      = inflight;
        if (accept && !pop)      inflight_next = inflight + CW'(1);
        else if (pop && !accept) inflight_next = inflight - CW'(1);
        case (state)
            CLEAR: begin
                if (clear_in) begin
                    sweep_next = '0;
                end else if (sweep == LAST_ADDR) begin
                    sweep_next = '0;
                    state_next = RUN;
                end else begin
                    sweep_next = sweep + ADDR_W'(1);
                end
            end
            RUN: begin
                if (clear_in) begin
                    clear_pending_next = 1'b1;
                    state_next         = DRAIN;
                end
            end
            DRAIN: begin
                if (inflight_next == '0) begin
                    state_next         = CLEAR;
                    sweep_next         = '0;
                    clear_pending_next = 1'b0;
                end
            end
            default: state_next = CLEAR;
        endcase
    end

    // The write port is one register fed by either the sweep or a writeback, never both.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state         <= CLEAR;
            sweep         <= '0;
            inflight      <= '0;
            clear_pending <= 1'b0;
            dl_valid      <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            clearing_q    <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state         <= state_next;
            sweep         <= sweep_next;
            inflight      <= inflight_next;
            clear_pending <= clear_pending_next;
            dl_valid[0]   <= accept;
            for (int i = 1; i < RD_LAT; i++) dl_valid[i] <= dl_valid[i-1];
            clearing_q    <= (state == CLEAR);
            if (iir_valid_in && !pop) err_q <= 1'b1;
            if (state == CLEAR) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= sweep;
                wr_data_q <= '0;
            end else if (pop) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= tag;
                wr_data_q <= iir_update_in;
            end else begin
                wr_en_q   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        dl_pixel[0] <= cam_pixel_in;
        for (int i = 1; i < RD_LAT; i++) dl_pixel[i] <= dl_pixel[i-1];
    end

endmodule

// File: tb/tb_trail_frame_sched.sv
// Directed bench for trail_frame_sched: each task drives one scenario and checks hand-computed values.
module tb_trail_frame_sched;

    localparam int ADDR_W       = 17;
    localparam int NUM_PIXELS   = 16;
    localparam int RD_LAT       = 2;
    localparam int MAX_INFLIGHT = 8;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              clear_in;
    logic              cam_valid_in;
    logic              cam_ready_out;
    logic [23:0]       cam_pixel_in;
    logic [ADDR_W-1:0] cam_addr_in;
    logic              hist_rd_en_out;
    logic [ADDR_W-1:0] hist_rd_addr_out;
    logic [23:0]       hist_rd_data_in;
    logic              iir_valid_out;
    logic [23:0]       iir_history_out;
    logic [23:0]       iir_camera_out;
    logic              iir_valid_in;
    logic [23:0]       iir_update_in;
    logic              hist_wr_en_out;
    logic [ADDR_W-1:0] hist_wr_addr_out;
    logic [23:0]       hist_wr_data_out;
    logic              clearing_out;
    logic              err_out;

    int checks = 0;
    int errors = 0;

    trail_frame_sched #(
        .ADDR_W       (ADDR_W),
        .NUM_PIXELS   (NUM_PIXELS),
        .RD_LAT       (RD_LAT),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .clear_in         (clear_in),
        .cam_valid_in     (cam_valid_in),
        .cam_ready_out    (cam_ready_out),
        .cam_pixel_in     (cam_pixel_in),
        .cam_addr_in      (cam_addr_in),
        .hist_rd_en_out   (hist_rd_en_out),
        .hist_rd_addr_out (hist_rd_addr_out),
        .hist_rd_data_in  (hist_rd_data_in),
        .iir_valid_out    (iir_valid_out),
        .iir_history_out  (iir_history_out),
        .iir_camera_out   (iir_camera_out),
        .iir_valid_in     (iir_valid_in),
        .iir_update_in    (iir_update_in),
        .hist_wr_en_out   (hist_wr_en_out),
        .hist_wr_addr_out (hist_wr_addr_out),
        .hist_wr_data_out (hist_wr_data_out),
        .clearing_out     (clearing_out),
        .err_out          (err_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_inputs();
        clear_in        = 1'b0;
        cam_valid_in    = 1'b0;
        cam_pixel_in    = '0;
        cam_addr_in     = '0;
        hist_rd_data_in = '0;
        iir_valid_in    = 1'b0;
        iir_update_in   = '0;
    endtask

    // Reset and let the power-up sweep finish; leaves the DUT ready in RUN.
    task automatic reset_dut();
        idle_inputs();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
        repeat (NUM_PIXELS + 1) tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_in = 1'b1;
        tick();
        tick();
        checks++;
        if (hist_wr_en_out !== 1'b0 || clearing_out !== 1'b0 || cam_ready_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs got wr=%b clr=%b rdy=%b expected 0 0 0",
                     hist_wr_en_out, clearing_out, cam_ready_out);
        end
        checks++;
        if (err_out !== 1'b0 || iir_valid_out !== 1'b0 || hist_rd_en_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_misc got err=%b iirv=%b rd=%b expected 0 0 0",
                     err_out, iir_valid_out, hist_rd_en_out);
        end
        rst_in = 1'b0;
        for (int i = 0; i < NUM_PIXELS; i++) begin
            tick();
            checks++;
            if (hist_wr_en_out !== 1'b1 || hist_wr_addr_out !== ADDR_W'(i) ||
                hist_wr_data_out !== 24'h0 || clearing_out !== 1'b1 || cam_ready_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL sweep_%0d got wr=%b addr=%0d data=%h clr=%b rdy=%b expected 1 %0d 000000 1 0",
                         i, hist_wr_en_out, hist_wr_addr_out, hist_wr_data_out, clearing_out,
                         cam_ready_out, i);
            end
        end
        tick();
        checks++;
        if (hist_wr_en_out !== 1'b0 || clearing_out !== 1'b0 || cam_ready_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sweep_end got wr=%b clr=%b rdy=%b expected 0 0 1",
                     hist_wr_en_out, clearing_out, cam_ready_out);
        end
    endtask

    task automatic test_single_pixel();
        reset_dut();
        cam_valid_in = 1'b1;
        cam_addr_in  = ADDR_W'(5);
        cam_pixel_in = 24'h123456;
        #1;
        checks++;
        if (hist_rd_en_out !== 1'b1 || hist_rd_addr_out !== ADDR_W'(5)) begin
            errors++;
            $display("[TB] FAIL single_read got en=%b addr=%0d expected 1 5", hist_rd_en_out, hist_rd_addr_out);
        end
        tick();
        cam_valid_in = 1'b0;
        #1;
        checks++;
        if (iir_valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_early_dispatch got %b expected 0", iir_valid_out);
        end
        tick();
        hist_rd_data_in = 24'hFAF078;
        #1;
        checks++;
        if (iir_valid_out !== 1'b1 || iir_history_out !== 24'hFAF078 || iir_camera_out !== 24'h123456) begin
            errors++;
            $display("[TB] FAIL single_dispatch got v=%b hist=%h cam=%h expected 1 faf078 123456",
                     iir_valid_out, iir_history_out, iir_camera_out);
        end
        tick();
        hist_rd_data_in = '0;
        iir_valid_in    = 1'b1;
        iir_update_in   = 24'hABCDEF;
        #1;
        checks++;
        if (iir_valid_out !== 1'b0 || hist_wr_en_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_post_dispatch got v=%b wr=%b expected 0 0", iir_valid_out, hist_wr_en_out);
        end
        tick();
        iir_valid_in = 1'b0;
        #1;
        checks++;
        if (hist_wr_en_out !== 1'b1 || hist_wr_addr_out !== ADDR_W'(5) || hist_wr_data_out !== 24'hABCDEF) begin
            errors++;
            $display("[TB] FAIL single_writeback got wr=%b addr=%0d data=%h expected 1 5 abcdef",
                     hist_wr_en_out, hist_wr_addr_out, hist_wr_data_out);
        end
        tick();
        checks++;
        if (hist_wr_en_out !== 1'b0 || err_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_after got wr=%b err=%b expected 0 0", hist_wr_en_out, err_out);
        end
    endtask

    // Ten pixels pushed back-to-back while trail_iir takes 20 cycles per pixel.
    task automatic test_back_to_back();
        int next_idx = 0;
        int wr_count = 0;
        int wb_idx   = 0;
        int sched[$];
        reset_dut();
        for (int c = 0; c < 60; c++) begin
            cam_valid_in  = (next_idx < 10);
            cam_addr_in   = ADDR_W'(next_idx);
            cam_pixel_in  = 24'h200000 + 24'(next_idx);
            iir_valid_in  = 1'b0;
            iir_update_in = '0;
            if (sched.size() > 0 && sched[0] == c) begin
                iir_valid_in  = 1'b1;
                iir_update_in = 24'hA00000 + 24'(wb_idx);
                wb_idx++;
                void'(sched.pop_front());
            end
            #1;
            if (c == 8) begin
                checks++;
                if (cam_ready_out !== 1'b0 || next_idx != 8) begin
                    errors++;
                    $display("[TB] FAIL bp_ready_drop got rdy=%b accepted=%0d expected 0 8", cam_ready_out, next_idx);
                end
            end
            if (c == 22 || c == 23) begin
                checks++;
                if (cam_ready_out !== (c == 23)) begin
                    errors++;
                    $display("[TB] FAIL bp_ready_cycle%0d got %b expected %b", c, cam_ready_out, (c == 23));
                end
            end
            if (cam_valid_in && cam_ready_out) next_idx++;
            if (iir_valid_out) sched.push_back(c + 20);
            if (hist_wr_en_out) begin
                checks++;
                if (hist_wr_addr_out !== ADDR_W'(wr_count) || hist_wr_data_out !== 24'hA00000 + 24'(wr_count)) begin
                    errors++;
                    $display("[TB] FAIL bp_write_%0d got addr=%0d data=%h expected %0d %h", wr_count,
                             hist_wr_addr_out, hist_wr_data_out, wr_count, 24'hA00000 + 24'(wr_count));
                end
                wr_count++;
            end
            tick();
        end
        idle_inputs();
        checks++;
        if (wr_count != 10 || err_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_write_count got %0d err=%b expected 10 0", wr_count, err_out);
        end
    endtask

    task automatic test_clear_mid_run();
        logic              exp_wr;
        logic              exp_rdy;
        logic              exp_clr;
        logic [ADDR_W-1:0] exp_addr;
        logic [23:0]       exp_data;
        reset_dut();
        for (int c = 0; c <= 26; c++) begin
            cam_valid_in  = (c < 3);
            cam_addr_in   = ADDR_W'(20 + c);
            cam_pixel_in  = 24'h0;
            clear_in      = (c == 3);
            iir_valid_in  = (c >= 5 && c <= 7);
            iir_update_in = 24'h0B0000 + 24'(c);
            #1;
            exp_wr  = (c >= 6 && c <= 24);
            exp_rdy = (c < 4) || (c >= 25);
            exp_clr = (c >= 9 && c <= 24);
            if (c <= 8) begin
                exp_addr = ADDR_W'(20 + c - 6);
                exp_data = 24'h0B0000 + 24'(c - 1);
            end else begin
                exp_addr = ADDR_W'(c - 9);
                exp_data = 24'h0;
            end
            checks++;
            if (cam_ready_out !== exp_rdy || clearing_out !== exp_clr) begin
                errors++;
                $display("[TB] FAIL clear_ctrl_c%0d got rdy=%b clr=%b expected %b %b",
                         c, cam_ready_out, clearing_out, exp_rdy, exp_clr);
            end
            checks++;
            if (hist_wr_en_out !== exp_wr ||
                (exp_wr && (hist_wr_addr_out !== exp_addr || hist_wr_data_out !== exp_data))) begin
                errors++;
                $display("[TB] FAIL clear_write_c%0d got wr=%b addr=%0d data=%h expected %b %0d %h",
                         c, hist_wr_en_out, hist_wr_addr_out, hist_wr_data_out, exp_wr, exp_addr, exp_data);
            end
            tick();
        end
        idle_inputs();
    endtask

    // Accept and writeback in the same cycle at seven in flight.
    task automatic test_simultaneous();
        reset_dut();
        for (int c = 0; c < 7; c++) begin
            cam_valid_in = 1'b1;
            cam_addr_in  = ADDR_W'(30 + c);
            tick();
        end
        cam_valid_in = 1'b0;
        tick();
        tick();
        cam_valid_in  = 1'b1;
        cam_addr_in   = ADDR_W'(37);
        iir_valid_in  = 1'b1;
        iir_update_in = 24'hC00030;
        #1;
        checks++;
        if (cam_ready_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_ready_at7 got %b expected 1", cam_ready_out);
        end
        tick();
        cam_addr_in  = ADDR_W'(38);
        iir_valid_in = 1'b0;
        #1;
        checks++;
        if (cam_ready_out !== 1'b1 || hist_wr_en_out !== 1'b1 || hist_wr_addr_out !== ADDR_W'(30) ||
            hist_wr_data_out !== 24'hC00030) begin
            errors++;
            $display("[TB] FAIL simul_after got rdy=%b wr=%b addr=%0d data=%h expected 1 1 30 c00030",
                     cam_ready_out, hist_wr_en_out, hist_wr_addr_out, hist_wr_data_out);
        end
        tick();
        cam_valid_in = 1'b0;
        #1;
        checks++;
        if (cam_ready_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_full got rdy=%b expected 0", cam_ready_out);
        end
        tick();
        for (int c = 12; c <= 21; c++) begin
            iir_valid_in  = (c <= 19);
            iir_update_in = 24'hC00000 + 24'(31 + c - 12);
            #1;
            if (c >= 13) begin
                checks++;
                if (c <= 20 && (hist_wr_en_out !== 1'b1 || hist_wr_addr_out !== ADDR_W'(31 + c - 13) ||
                                hist_wr_data_out !== 24'hC00000 + 24'(31 + c - 13))) begin
                    errors++;
                    $display("[TB] FAIL simul_drain_c%0d got wr=%b addr=%0d data=%h expected 1 %0d",
                             c, hist_wr_en_out, hist_wr_addr_out, hist_wr_data_out, 31 + c - 13);
                end else if (c == 21 && (hist_wr_en_out !== 1'b0 || cam_ready_out !== 1'b1 || err_out !== 1'b0)) begin
                    errors++;
                    $display("[TB] FAIL simul_end got wr=%b rdy=%b err=%b expected 0 1 0",
                             hist_wr_en_out, cam_ready_out, err_out);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_error_reset();
        reset_dut();
        iir_valid_in  = 1'b1;
        iir_update_in = 24'h777777;
        tick();
        iir_valid_in = 1'b0;
        #1;
        checks++;
        if (err_out !== 1'b1 || hist_wr_en_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL err_set got err=%b wr=%b expected 1 0", err_out, hist_wr_en_out);
        end
        tick();
        clear_in = 1'b1;
        tick();
        clear_in = 1'b0;
        tick();
        tick();
        for (int k = 0; k <= 9; k++) begin
            #1;
            checks++;
            if (hist_wr_en_out !== 1'b1 || hist_wr_addr_out !== ADDR_W'(k) || err_out !== 1'b1) begin
                errors++;
                $display("[TB] FAIL err_sweep_%0d got wr=%b addr=%0d err=%b expected 1 %0d 1",
                         k, hist_wr_en_out, hist_wr_addr_out, err_out, k);
            end
            if (k < 9) tick();
        end
        rst_in = 1'b1;
        #1;
        checks++;
        if (hist_wr_en_out !== 1'b0 || hist_wr_addr_out !== '0 || clearing_out !== 1'b0 ||
            err_out !== 1'b0 || cam_ready_out !== 1'b0 || iir_valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midsweep_reset got wr=%b addr=%0d clr=%b err=%b rdy=%b iirv=%b expected all 0",
                     hist_wr_en_out, hist_wr_addr_out, clearing_out, err_out, cam_ready_out, iir_valid_out);
        end
        tick();
        tick();
        rst_in = 1'b0;
        tick();
        checks++;
        if (hist_wr_en_out !== 1'b1 || hist_wr_addr_out !== ADDR_W'(0) || clearing_out !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_addr0 got wr=%b addr=%0d clr=%b expected 1 0 1",
                     hist_wr_en_out, hist_wr_addr_out, clearing_out);
        end
        tick();
        checks++;
        if (hist_wr_en_out !== 1'b1 || hist_wr_addr_out !== ADDR_W'(1)) begin
            errors++;
            $display("[TB] FAIL restart_addr1 got wr=%b addr=%0d expected 1 1", hist_wr_en_out, hist_wr_addr_out);
        end
    endtask

    initial begin
        $display("[TB] starting trail_frame_sched bench");
        test_reset();
        test_single_pixel();
        test_back_to_back();
        test_clear_mid_run();
        test_simultaneous();
        test_error_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
